// File: rtl/ram_controller.sv
// ram_controller: word-organised on-chip RAM behind a byte-addressed,
// level-select request port. A request is accepted on a posedge and
// completes LATENCY posedges later. While the request stays selected and
// unchanged, finish_Out and data_Out hold. Changing the request restarts it.
// Dropping select aborts the request, and no write is performed.
//
// Ports:
//   clk            clock; all state changes on posedge
//   rst            asynchronous active-low reset
//   addr_In        byte offset into the RAM region
//   data_In        write data, right-aligned
//   dataWidth_In   access width (`MEM_WIDTH_BYTE/HALF/WORD, 2'b00 is illegal)
//   isRead_In      1 = read, 0 = write
//   select_In      request valid (level)
//   finish_Out     registered; the request has completed
//   data_Out       registered read data, zero-extended and right-aligned
//   exception_Out  combinational status of the live request

`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b01
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b10
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b11
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'h4
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'h5
`endif

module ram_controller #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2
`ifdef RAM_INIT_EN
    ,
    parameter string       INIT_FILE   = "ram.hex"
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                addr_In,
    input  logic [31:0]                data_In,
    input  logic [1:0]                 dataWidth_In,
    input  logic                       isRead_In,
    input  logic                       select_In,
    output logic                       finish_Out,
    output logic [31:0]                data_Out,
    output logic [`EXCEPTION_LEN-1:0]  exception_Out
);

    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_width;
    logic        r_is_read;
    logic        r_err;
    logic [3:0]  r_cnt;
    logic        r_finish;
    logic [31:0] r_dout;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic              w_err;
    logic              w_differs;
    logic              w_complete;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rd_shift;
    logic [31:0]       w_rd_fmt;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    // Request error check on the live inputs: alignment, range, encoding
    always_comb begin
        w_err = 1'b0;
        case (dataWidth_In)
            `MEM_WIDTH_BYTE: w_err = 1'b0;
            `MEM_WIDTH_HALF: w_err = addr_In[0];
            `MEM_WIDTH_WORD: w_err = |addr_In[1:0];
            default:         w_err = 1'b1;
        endcase
        if ({1'b0, addr_In} >= BYTE_LIMIT) begin
            w_err = 1'b1;
        end
    end

    assign exception_Out = (!select_In || !w_err) ? `EXCEP_OK :
                           (isRead_In ? `EXCEP_INVALID_MEM_READ : `EXCEP_INVALID_MEM_WRITE);

    // Any change to the live request while it is in flight restarts it
    assign w_differs = ({addr_In, data_In, dataWidth_In, isRead_In}
                        != {r_addr, r_data, r_width, r_is_read});

    assign w_complete = (r_state == S_BUSY) && select_In && !w_differs && (r_cnt == 4'd0);
    assign w_wr_en    = w_complete && !r_is_read && !r_err;

    // Out-of-range requests are flagged as errors, so this index is only
    // used for requests that are inside the array
    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {r_addr[1:0], 3'b000};

    // Lane enables and replicated write data for sub-word stores
    always_comb begin
        w_be     = 4'b0000;
        w_wdata  = r_data;
        w_rd_fmt = 32'h0;
        case (r_width)
            `MEM_WIDTH_BYTE: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wdata  = {4{r_data[7:0]}};
                w_rd_fmt = {24'h0, w_rd_shift[7:0]};
            end
            `MEM_WIDTH_HALF: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{r_data[15:0]}};
                w_rd_fmt = {16'h0, w_rd_shift[15:0]};
            end
            `MEM_WIDTH_WORD: begin
                w_be     = 4'b1111;
                w_rd_fmt = w_rd_word;
            end
            default: begin
                w_be     = 4'b0000;
                w_rd_fmt = 32'h0;
            end
        endcase
    end

    // Storage array; never reset, written only on a completing edge
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request FSM with latch, latency counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'h0;
            r_data    <= 32'h0;
            r_width   <= 2'b00;
            r_is_read <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= 4'd0;
            r_finish  <= 1'b0;
            r_dout    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_finish <= 1'b0;
                    r_dout   <= 32'h0;
                    if (select_In) begin
                        r_addr    <= addr_In;
                        r_data    <= data_In;
                        r_width   <= dataWidth_In;
                        r_is_read <= isRead_In;
                        r_err     <= w_err;
                        r_cnt     <= LAT_LOAD;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!select_In) begin
                        r_state <= S_IDLE;
                    end else if (w_differs) begin
                        r_addr    <= addr_In;
                        r_data    <= data_In;
                        r_width   <= dataWidth_In;
                        r_is_read <= isRead_In;
                        r_err     <= w_err;
                        r_cnt     <= LAT_LOAD;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_finish <= 1'b1;
                        r_dout   <= (r_is_read && !r_err) ? w_rd_fmt : 32'h0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!select_In) begin
                        r_finish <= 1'b0;
                        r_dout   <= 32'h0;
                        r_state  <= S_IDLE;
                    end else if (w_differs) begin
                        r_finish  <= 1'b0;
                        r_addr    <= addr_In;
                        r_data    <= data_In;
                        r_width   <= dataWidth_In;
                        r_is_read <= isRead_In;
                        r_err     <= w_err;
                        r_cnt     <= LAT_LOAD;
                        r_state   <= S_BUSY;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_finish <= 1'b0;
                    r_dout   <= 32'h0;
                end
            endcase
        end
    end

    assign finish_Out = r_finish;
    assign data_Out   = r_dout;

endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: directed, table-driven bench for ram_controller
// (DEPTH_WORDS=4096, LATENCY=2), plus hand-written sequences for abort,
// back-to-back restart from DONE and asynchronous reset mid-request.

`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b01
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b10
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b11
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'h4
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'h5
`endif

module tb_ram_controller;

    localparam int unsigned LAT   = 2;
    localparam int unsigned NVEC  = 22;
    localparam int unsigned BOUND = 20;

    typedef struct {
        logic [31:0]               addr;
        logic [31:0]               data;
        logic [1:0]                width;
        logic                      rd;
        logic [31:0]               exp_data;
        logic [`EXCEPTION_LEN-1:0] exp_exc;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [31:0]               addr_In = 32'h0;
    logic [31:0]               data_In = 32'h0;
    logic [1:0]                dataWidth_In = 2'b00;
    logic                      isRead_In = 1'b0;
    logic                      select_In = 1'b0;
    logic                      finish_Out;
    logic [31:0]               data_Out;
    logic [`EXCEPTION_LEN-1:0] exception_Out;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NVEC];

    ram_controller #(
        .DEPTH_WORDS (4096),
        .LATENCY     (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr_In       (addr_In),
        .data_In       (data_In),
        .dataWidth_In  (dataWidth_In),
        .isRead_In     (isRead_In),
        .select_In     (select_In),
        .finish_Out    (finish_Out),
        .data_Out      (data_Out),
        .exception_Out (exception_Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] w, input logic r);
        addr_In      = a;
        data_In      = d;
        dataWidth_In = w;
        isRead_In    = r;
        select_In    = 1'b1;
    endtask

    // Counts posedges (sampled on the following negedge) until finish_Out
    task automatic wait_finish(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end while (!finish_Out && cnt < int'(BOUND));
    endtask

    // Full request: drive, check status, latency, data, then release
    task automatic run_req(input vec_t v, input int idx);
        int cnt;
        drive(v.addr, v.data, v.width, v.rd);
        #1;
        check($sformatf("v%0d exception", idx), 32'(exception_Out), 32'(v.exp_exc));
        wait_finish(cnt);
        // accepting edge plus LATENCY edges
        check($sformatf("v%0d latency", idx), 32'(cnt), 32'(LAT + 1));
        check($sformatf("v%0d data", idx), data_Out, v.exp_data);
        check($sformatf("v%0d exception in DONE", idx), 32'(exception_Out), 32'(v.exp_exc));
        select_In = 1'b0;
        #1;
        check($sformatf("v%0d exception deselected", idx), 32'(exception_Out), 32'(`EXCEP_OK));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d finish cleared", idx), 32'(finish_Out), 32'h0);
        check($sformatf("v%0d data cleared", idx), data_Out, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        vec_t v;

        vecs[0]  = '{32'h10,   32'hDEADBEEF, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[1]  = '{32'h10,   32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'hDEADBEEF, `EXCEP_OK};
        vecs[2]  = '{32'h10,   32'h11223344, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[3]  = '{32'h13,   32'h000000AA, `MEM_WIDTH_BYTE, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[4]  = '{32'h10,   32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'hAA223344, `EXCEP_OK};
        vecs[5]  = '{32'h13,   32'h0,        `MEM_WIDTH_BYTE, 1'b1, 32'h000000AA, `EXCEP_OK};
        vecs[6]  = '{32'h12,   32'h0,        `MEM_WIDTH_HALF, 1'b1, 32'h0000AA22, `EXCEP_OK};
        vecs[7]  = '{32'h11,   32'h0,        `MEM_WIDTH_HALF, 1'b1, 32'h0,        `EXCEP_INVALID_MEM_READ};
        vecs[8]  = '{32'h4002, 32'h0BADBEEF, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_INVALID_MEM_WRITE};
        vecs[9]  = '{32'h3FFC, 32'hCAFEF00D, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[10] = '{32'h3FFC, 32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'hCAFEF00D, `EXCEP_OK};
        vecs[11] = '{32'h4000, 32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'h0,        `EXCEP_INVALID_MEM_READ};
        vecs[12] = '{32'h10,   32'hFFFFFFFF, 2'b00,           1'b0, 32'h0,        `EXCEP_INVALID_MEM_WRITE};
        vecs[13] = '{32'h10,   32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'hAA223344, `EXCEP_OK};
        vecs[14] = '{32'h20,   32'h55667788, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[15] = '{32'h14,   32'h01020304, `MEM_WIDTH_WORD, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[16] = '{32'h16,   32'h0000BEEF, `MEM_WIDTH_HALF, 1'b0, 32'h0,        `EXCEP_OK};
        vecs[17] = '{32'h14,   32'h0,        `MEM_WIDTH_WORD, 1'b1, 32'hBEEF0304, `EXCEP_OK};
        vecs[18] = '{32'h15,   32'h0,        `MEM_WIDTH_BYTE, 1'b1, 32'h00000003, `EXCEP_OK};
        vecs[19] = '{32'h16,   32'h0,        `MEM_WIDTH_HALF, 1'b1, 32'h0000BEEF, `EXCEP_OK};
        vecs[20] = '{32'h3FFF, 32'h0,        `MEM_WIDTH_BYTE, 1'b1, 32'h000000CA, `EXCEP_OK};
        vecs[21] = '{32'h11,   32'h0,        `MEM_WIDTH_BYTE, 1'b1, 32'h00000033, `EXCEP_OK};

        // Reset state
        #2;
        check("reset finish", 32'(finish_Out), 32'h0);
        check("reset data", data_Out, 32'h0);
        check("reset exception", 32'(exception_Out), 32'(`EXCEP_OK));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_req(vecs[i], i);
        end

        // Abort: drop select after one cycle in BUSY, no write may happen
        drive(32'h20, 32'h12345678, `MEM_WIDTH_WORD, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        select_In = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("abort finish c%0d", i), 32'(finish_Out), 32'h0);
        end
        v = '{32'h20, 32'h0, `MEM_WIDTH_WORD, 1'b1, 32'h55667788, `EXCEP_OK};
        run_req(v, 100);

        // Back-to-back: change address while held in DONE
        drive(32'h10, 32'h0, `MEM_WIDTH_WORD, 1'b1);
        wait_finish(cnt);
        check("b2b first latency", 32'(cnt), 32'(LAT + 1));
        check("b2b first data", data_Out, 32'hAA223344);
        addr_In = 32'h14;
        @(posedge clk);
        @(negedge clk);
        check("b2b finish drops", 32'(finish_Out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("b2b finish still low", 32'(finish_Out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("b2b finish re-rises", 32'(finish_Out), 32'h1);
        check("b2b second data", data_Out, 32'hBEEF0304);

        // Async reset mid-BUSY of a write entered straight from DONE
        drive(32'h10, 32'h99999999, `MEM_WIDTH_WORD, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid-busy reset finish", 32'(finish_Out), 32'h0);
        check("mid-busy reset data", data_Out, 32'h0);
        select_In = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = '{32'h10, 32'h0, `MEM_WIDTH_WORD, 1'b1, 32'hAA223344, `EXCEP_OK};
        run_req(v, 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
